// File: rtl/spi_req_arbiter_if.sv
// Bundle between the requester clients, the arbiter and the shared spi_master.
// The arbiter side uses the slave modport; clients plus the master use master.
interface spi_req_arbiter_if #(
  parameter int NREQ = 2
);
  // Handshake: a requester raises req[i] with req_rd[i]/req_data[i] stable and
  // holds it until done[i] pulses for one cycle; gnt[i] marks the transfer owner.
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_rd;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [7:0]        rsp_data;
  logic              busy;
  logic              timeout;
  logic              spi_load;
  logic              spi_start;
  logic              spi_read;
  logic [7:0]        spi_data_in;
  logic [7:0]        spi_data_out;
  logic              spi_cs;

  modport slave (
    input  req, req_rd, req_data, spi_data_out, spi_cs,
    output gnt, done, rsp_data, busy, timeout,
           spi_load, spi_start, spi_read, spi_data_in
  );

  modport master (
    output req, req_rd, req_data, spi_data_out, spi_cs,
    input  gnt, done, rsp_data, busy, timeout,
           spi_load, spi_start, spi_read, spi_data_in
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master between NREQ byte requesters.
// Optional macro SPI_ARB_TIMEOUT_EN adds a per-wait-state abort counter.
module spi_req_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             mclk,
  input  logic             reset,
  spi_req_arbiter_if.slave bus,
  output logic [2:0]       dbg_state
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_CS = 3'd2,
    BUSY    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic [7:0]      r_rsp, w_rsp_nxt;
  logic [7:0]      r_din, w_din_nxt;
  logic            r_read, w_read_nxt;
  logic            r_kick, w_kick_nxt;
  logic            r_to, w_to_nxt;
  logic            r_busy, w_busy_nxt;
  logic            w_win_found;
  logic [PW-1:0]   w_win_idx;
  logic            w_expire;

  // First requester at or after the pointer, wrapping past NREQ-1.
  always_comb begin : winner_scan
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_win_found && bus.req[(int'(r_ptr) + i) % NREQ]) begin
        w_win_found = 1'b1;
        w_win_idx   = PW'((int'(r_ptr) + i) % NREQ);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;

  // Any state change restarts the count, which covers entry to WAIT_CS and BUSY.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_state == WAIT_CS || r_state == BUSY) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_expire = (r_state == WAIT_CS || r_state == BUSY) && (r_cnt == CW'(TIMEOUT_CYC));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge mclk or negedge reset) begin : state_reg
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_rsp   <= 8'h00;
      r_din   <= 8'h00;
      r_read  <= 1'b0;
      r_kick  <= 1'b0;
      r_to    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_rsp   <= w_rsp_nxt;
      r_din   <= w_din_nxt;
      r_read  <= w_read_nxt;
      r_kick  <= w_kick_nxt;
      r_to    <= w_to_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin : next_state
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_win_found) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = WAIT_CS;
      WAIT_CS: begin
        if (!bus.spi_cs)   w_state_nxt = BUSY;
        else if (w_expire) w_state_nxt = DONE;
      end
      BUSY:    if (bus.spi_cs || w_expire) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin : outputs
    w_ptr_nxt  = r_ptr;
    w_gnt_nxt  = r_gnt;
    w_done_nxt = '0;
    w_rsp_nxt  = r_rsp;
    w_din_nxt  = r_din;
    w_read_nxt = r_read;
    w_kick_nxt = 1'b0;
    w_to_nxt   = 1'b0;
    w_busy_nxt = (w_state_nxt != IDLE);
    case (r_state)
      IDLE: begin
        if (w_win_found) begin
          w_gnt_nxt            = '0;
          w_gnt_nxt[w_win_idx] = 1'b1;
          w_din_nxt            = bus.req_data[8*int'(w_win_idx) +: 8];
          w_read_nxt           = bus.req_rd[w_win_idx];
          w_kick_nxt           = 1'b1;
          w_ptr_nxt            = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
        end
      end
      WAIT_CS, BUSY: begin
        // cs rising in BUSY wins over an expiry on the same edge.
        if (w_state_nxt == DONE) begin
          w_done_nxt = r_gnt;
          w_gnt_nxt  = '0;
          if (r_state == BUSY && bus.spi_cs) begin
            w_rsp_nxt = bus.spi_data_out;
          end else begin
            w_rsp_nxt = 8'h00;
            w_to_nxt  = 1'b1;
          end
        end
      end
      DONE:    w_rsp_nxt = 8'h00;
      default: ;
    endcase
  end

  assign bus.gnt         = r_gnt;
  assign bus.done        = r_done;
  assign bus.rsp_data    = r_rsp;
  assign bus.busy        = r_busy;
  assign bus.timeout     = r_to;
  assign bus.spi_load    = r_kick;
  assign bus.spi_start   = r_kick;
  assign bus.spi_read    = r_read;
  assign bus.spi_data_in = r_din;
  assign dbg_state       = r_state;
endmodule
